// File: rtl/wb8_master_arbiter_pkg.sv
// Shared constants for the two-master 8-bit Wishbone arbiter: FSM encodings,
// default timeout and the per-master control bundle used by the owner mux.
package wb8_master_arbiter_pkg;

  localparam logic [1:0] ARB_IDLE    = 2'd0;
  localparam logic [1:0] ARB_OWN0    = 2'd1;
  localparam logic [1:0] ARB_OWN1    = 2'd2;
  localparam logic [1:0] ARB_RELEASE = 2'd3;

  localparam int TIMEOUT_CYCLES_DEF = 1023;

  typedef struct packed {
    logic       cyc;
    logic       stb;
    logic       we;
    logic [7:0] dat;
  } wb8_ctl_t;

endpackage

// File: rtl/wb8_arb_timeout.sv
// Hung-slave watchdog: counts owner cycles without ACK and flags the cycle in
// which the count reaches TIMEOUT_CYCLES-1.
module wb8_arb_timeout
  import wb8_master_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic ack,
  output logic hit
);

  localparam logic [15:0] LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt;

  assign hit = active & ~ack & (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    cnt <= '0;
    else if (!active || ack || hit) cnt <= '0;
    else                           cnt <= cnt + 16'd1;
  end

endmodule

// File: rtl/wb8_master_arbiter.sv
// Two-master, one-slave 8-bit Wishbone arbiter, round-robin at CYC boundaries.
// Define WB8ARB_TIMEOUT_EN to add the no-ACK watchdog that forces a release.
module wb8_master_arbiter
  import wb8_master_arbiter_pkg::*;
#(
  parameter int ADDRBITS       = 32,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                I_clk,
  input  logic                I_reset_n,
  input  logic                I_m0_cyc,
  input  logic                I_m0_stb,
  input  logic                I_m0_we,
  input  logic [ADDRBITS-1:0] I_m0_adr,
  input  logic [7:0]          I_m0_dat,
  output logic [7:0]          O_m0_dat,
  output logic                O_m0_ack,
  output logic                O_m0_stall,
  output logic                O_m0_err,
  input  logic                I_m1_cyc,
  input  logic                I_m1_stb,
  input  logic                I_m1_we,
  input  logic [ADDRBITS-1:0] I_m1_adr,
  input  logic [7:0]          I_m1_dat,
  output logic [7:0]          O_m1_dat,
  output logic                O_m1_ack,
  output logic                O_m1_stall,
  output logic                O_m1_err,
  output logic                O_wb_cyc,
  output logic                O_wb_stb,
  output logic                O_wb_we,
  output logic [ADDRBITS-1:0] O_wb_adr,
  output logic [7:0]          O_wb_dat,
  input  logic [7:0]          I_wb_dat,
  input  logic                I_wb_ack,
  input  logic                I_wb_stall,
  output logic [1:0]          O_grant
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range 2..65535");
  end

  logic [1:0] state, nxt;
  logic       last_own;   // 1 => M1 owned last, so M0 wins the next tie
  logic       own0, own1, tmo_hit;
  wb8_ctl_t   m0_ctl, m1_ctl, sel;

  assign own0   = (state == ARB_OWN0);
  assign own1   = (state == ARB_OWN1);
  assign m0_ctl = '{cyc: I_m0_cyc, stb: I_m0_stb, we: I_m0_we, dat: I_m0_dat};
  assign m1_ctl = '{cyc: I_m1_cyc, stb: I_m1_stb, we: I_m1_we, dat: I_m1_dat};
  assign sel    = own0 ? m0_ctl : own1 ? m1_ctl : '0;

`ifdef WB8ARB_TIMEOUT_EN
  wb8_arb_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
    .clk    (I_clk),
    .rst_n  (I_reset_n),
    .active (sel.cyc),
    .ack    (I_wb_ack),
    .hit    (tmo_hit)
  );
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    nxt = state;
    case (state)
      ARB_IDLE: begin
        if (I_m0_cyc && I_m1_cyc) nxt = last_own ? ARB_OWN0 : ARB_OWN1;
        else if (I_m0_cyc)        nxt = ARB_OWN0;
        else if (I_m1_cyc)        nxt = ARB_OWN1;
      end
      ARB_OWN0: if (!I_m0_cyc || tmo_hit) nxt = ARB_RELEASE;
      ARB_OWN1: if (!I_m1_cyc || tmo_hit) nxt = ARB_RELEASE;
      default:  nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      state    <= ARB_IDLE;
      last_own <= 1'b1;
    end else begin
      state <= nxt;
      if (nxt == ARB_RELEASE && (own0 || own1)) last_own <= own1;
    end
  end

  // A watchdog hit drops the slave cycle in the same cycle the ERR pulses.
  assign O_wb_cyc = sel.cyc & ~tmo_hit;
  assign O_wb_stb = sel.stb & ~tmo_hit;
  assign O_wb_we  = sel.we;
  assign O_wb_dat = sel.dat;
  assign O_wb_adr = own0 ? I_m0_adr : own1 ? I_m1_adr : '0;

  assign O_m0_ack   = own0 & I_wb_ack;
  assign O_m0_stall = own0 ? I_wb_stall : 1'b1;
  assign O_m0_dat   = own0 ? I_wb_dat : 8'h00;
  assign O_m0_err   = own0 & tmo_hit;
  assign O_m1_ack   = own1 & I_wb_ack;
  assign O_m1_stall = own1 ? I_wb_stall : 1'b1;
  assign O_m1_dat   = own1 ? I_wb_dat : 8'h00;
  assign O_m1_err   = own1 & tmo_hit;

  assign O_grant = {own1, own0};

endmodule
